ps2_key_mapper: RTL and testbench



---
 rtl/ps2_key_mapper.sv | 240 ++++++++++++++++++++++++
 tb/tb_ps2_key_mapper.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_mapper.sv
// ps2_key_mapper
// ---------------------------------------------------------------------------
// Turns the decoded PS/2 Set 2 scancode byte stream into synth control
// signals. The parser handles E0 (extended) and F0 (break) prefixes. The
// mapper implements last-pressed note priority and one-cycle control pulses.
// Control-key typematic repeats are suppressed unless the build enables
// repeat.
//
// Build option:
//   KEYMAP_REPEAT_EN  when defined, every make of a control key pulses,
//                     including typematic repeats. Held flags are kept
//                     either way.
//
// Parameter:
//   PREFIX_TIMEOUT    idle cycles after a prefix byte before the parser gives
//                     up on the sequence and returns to IDLE.
//
// Ports:
//   clk, reset                 clock; asynchronous active-high reset
//   rx_data[7:0], rx_valid     scancode byte and its one-cycle strobe
//                              (no backpressure; every strobed byte is taken)
//   note[3:0], note_in         current note 0..12 and its held level
//   octave_/amp_/ADSR_ plus_plus/minus_minus
//                              one-cycle increment/decrement pulses
//   ADSR_selector[2:0]         0 amp, 1 attack, 2 decay, 3 sustain, 4 release
//   dbg_state[1:0]             parser state (0 IDLE, 1 EXT, 2 BRK, 3 EXT_BRK)
//
// Handshake: rx_valid qualifies rx_data for exactly the cycle it is high.
// Each strobed byte is consumed on that clock edge. All outputs are
// registered and reflect a completed sequence one cycle after its final byte.
// ---------------------------------------------------------------------------
module ps2_key_mapper #(
  parameter int unsigned PREFIX_TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] note,
  output logic       note_in,
  output logic       octave_plus_plus,
  output logic       octave_minus_minus,
  output logic       amp_plus_plus,
  output logic       amp_minus_minus,
  output logic       ADSR_plus_plus,
  output logic       ADSR_minus_minus,
  output logic [2:0] ADSR_selector,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam int unsigned CNT_W = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

`ifdef KEYMAP_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  // Control key indices into the held/pulse vectors:
  // 0 octave-, 1 octave+, 2 amp-, 3 amp+, 4 ADSR- (E0 6B), 5 ADSR+ (E0 74)
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       note_q, note_d;
  logic             note_in_q, note_in_d;
  logic [5:0]       held_q, held_d;
  logic [5:0]       pulse_q, pulse_d;
  logic [2:0]       sel_q, sel_d;

  // Parser outputs: one completed key event per accepted byte at most
  logic ev_valid, ev_ext, ev_brk;

  // Byte decode
  logic       note_hit;
  logic [3:0] note_code;
  logic       ctl_n_hit, ctl_e_hit;
  logic [2:0] ctl_idx;
  logic       sel_hit;
  logic [2:0] sel_val;
  logic       ignored;

  always_comb begin : decode
    note_hit  = 1'b0;
    note_code = 4'd0;
    ctl_n_hit = 1'b0;
    ctl_e_hit = 1'b0;
    ctl_idx   = 3'd0;
    sel_hit   = 1'b0;
    sel_val   = 3'd0;
    case (rx_data)
      8'h1C: begin note_hit = 1'b1; note_code = 4'd0;  end
      8'h1D: begin note_hit = 1'b1; note_code = 4'd1;  end
      8'h1B: begin note_hit = 1'b1; note_code = 4'd2;  end
      8'h24: begin note_hit = 1'b1; note_code = 4'd3;  end
      8'h23: begin note_hit = 1'b1; note_code = 4'd4;  end
      8'h2B: begin note_hit = 1'b1; note_code = 4'd5;  end
      8'h2C: begin note_hit = 1'b1; note_code = 4'd6;  end
      8'h34: begin note_hit = 1'b1; note_code = 4'd7;  end
      8'h35: begin note_hit = 1'b1; note_code = 4'd8;  end
      8'h33: begin note_hit = 1'b1; note_code = 4'd9;  end
      8'h3C: begin note_hit = 1'b1; note_code = 4'd10; end
      8'h3B: begin note_hit = 1'b1; note_code = 4'd11; end
      8'h42: begin note_hit = 1'b1; note_code = 4'd12; end
      8'h1A: begin ctl_n_hit = 1'b1; ctl_idx = 3'd0; end
      8'h22: begin ctl_n_hit = 1'b1; ctl_idx = 3'd1; end
      8'h4E: begin ctl_n_hit = 1'b1; ctl_idx = 3'd2; end
      8'h55: begin ctl_n_hit = 1'b1; ctl_idx = 3'd3; end
      8'h6B: begin ctl_e_hit = 1'b1; ctl_idx = 3'd4; end
      8'h74: begin ctl_e_hit = 1'b1; ctl_idx = 3'd5; end
      8'h16: begin sel_hit = 1'b1; sel_val = 3'd0; end
      8'h1E: begin sel_hit = 1'b1; sel_val = 3'd1; end
      8'h26: begin sel_hit = 1'b1; sel_val = 3'd2; end
      8'h25: begin sel_hit = 1'b1; sel_val = 3'd3; end
      8'h2E: begin sel_hit = 1'b1; sel_val = 3'd4; end
      default: ;
    endcase
    // Keyboard status/ack bytes that can show up in the stream
    ignored = (rx_data == 8'hAA) || (rx_data == 8'hFA) || (rx_data == 8'hFE) ||
              (rx_data == 8'hEE) || (rx_data == 8'h00) || (rx_data == 8'hFF);
  end

  always_comb begin : parser
    state_d  = state_q;
    cnt_d    = cnt_q;
    ev_valid = 1'b0;
    ev_ext   = 1'b0;
    ev_brk   = 1'b0;
    if (rx_valid) begin
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (rx_data == 8'hE0)      state_d = EXT;
          else if (rx_data == 8'hF0) state_d = BRK;
          else if (!ignored)         ev_valid = 1'b1;
        end
        EXT: begin
          if (rx_data == 8'hF0) begin
            state_d = EXT_BRK;
          end else begin
            ev_valid = 1'b1;
            ev_ext   = 1'b1;
            state_d  = IDLE;
          end
        end
        BRK: begin
          state_d = IDLE;
          if (rx_data != 8'hE0) begin
            ev_valid = 1'b1;
            ev_brk   = 1'b1;
          end
        end
        default: begin // EXT_BRK
          state_d = IDLE;
          if ((rx_data != 8'hE0) && (rx_data != 8'hF0)) begin
            ev_valid = 1'b1;
            ev_ext   = 1'b1;
            ev_brk   = 1'b1;
          end
        end
      endcase
    end else if (state_q != IDLE) begin
      // An accepted byte wins over an expiring timeout in the same cycle
      if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin : mapper
    note_d    = note_q;
    note_in_d = note_in_q;
    held_d    = held_q;
    pulse_d   = '0;
    sel_d     = sel_q;
    if (ev_valid) begin
      if (note_hit && !ev_ext) begin
        if (!ev_brk) begin
          // Last-pressed priority; a repeat of the held note changes nothing
          if ((note_code != note_q) || !note_in_q) begin
            note_d    = note_code;
            note_in_d = 1'b1;
          end
        end else if (note_code == note_q) begin
          note_in_d = 1'b0;
        end
      end
      if (ev_ext ? ctl_e_hit : ctl_n_hit) begin
        if (!ev_brk) begin
          if (!held_q[ctl_idx] || REPEAT_EN) pulse_d[ctl_idx] = 1'b1;
          held_d[ctl_idx] = 1'b1;
        end else begin
          held_d[ctl_idx] = 1'b0;
        end
      end
      if (sel_hit && !ev_ext && !ev_brk) sel_d = sel_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      note_q    <= 4'd0;
      note_in_q <= 1'b0;
      held_q    <= '0;
      pulse_q   <= '0;
      sel_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      note_q    <= note_d;
      note_in_q <= note_in_d;
      held_q    <= held_d;
      pulse_q   <= pulse_d;
      sel_q     <= sel_d;
    end
  end

  assign note               = note_q;
  assign note_in            = note_in_q;
  assign octave_minus_minus = pulse_q[0];
  assign octave_plus_plus   = pulse_q[1];
  assign amp_minus_minus    = pulse_q[2];
  assign amp_plus_plus      = pulse_q[3];
  assign ADSR_minus_minus   = pulse_q[4];
  assign ADSR_plus_plus     = pulse_q[5];
  assign ADSR_selector      = sel_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_ps2_key_mapper.sv
// tb_ps2_key_mapper
// Directed sequences from the key-mapper behaviour plus randomized byte
// streams. The reference model interprets the byte stream as a queue of
// pending prefix bytes and applies the key rules to a model of the synth
// state. Expected pulse vectors flow through a scoreboard queue.
module tb_ps2_key_mapper;

  localparam int T = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [3:0] note;
  logic       note_in;
  logic       octave_plus_plus, octave_minus_minus;
  logic       amp_plus_plus, amp_minus_minus;
  logic       ADSR_plus_plus, ADSR_minus_minus;
  logic [2:0] ADSR_selector;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  ps2_key_mapper #(.PREFIX_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .note(note), .note_in(note_in),
    .octave_plus_plus(octave_plus_plus), .octave_minus_minus(octave_minus_minus),
    .amp_plus_plus(amp_plus_plus), .amp_minus_minus(amp_minus_minus),
    .ADSR_plus_plus(ADSR_plus_plus), .ADSR_minus_minus(ADSR_minus_minus),
    .ADSR_selector(ADSR_selector), .dbg_state(dbg_state)
  );

`ifdef KEYMAP_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  // ---------------- check task ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] note_tbl [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                                8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};
  logic [7:0] ctl_tbl [6]   = '{8'h1A, 8'h22, 8'h4E, 8'h55, 8'h6B, 8'h74};
  bit         ctl_ext [6]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] sel_tbl [5]   = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
  logic [7:0] ign_tbl [6]   = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  logic [7:0] pre[$];        // prefix bytes of the sequence in progress
  int         gap = 0;       // idle cycles since the last byte
  int         m_note = 0;
  bit         m_in = 1'b0;
  bit [5:0]   m_held = '0;
  int         m_sel = 0;
  logic [5:0] m_pulse;
  logic [5:0] exp_q[$];      // expected pulse vector per cycle
  int         pulse_cnt [6];

  task automatic model_reset();
    pre.delete();
    gap = 0; m_note = 0; m_in = 1'b0; m_held = '0; m_sel = 0;
  endtask

  task automatic model_event(input bit brk, input bit ext, input logic [7:0] b);
    if (!ext) begin
      for (int i = 0; i < 13; i++) begin
        if (note_tbl[i] == b) begin
          if (!brk) begin
            if (i != m_note || !m_in) begin m_note = i; m_in = 1'b1; end
          end else if (i == m_note) begin
            m_in = 1'b0;
          end
        end
      end
      if (!brk)
        for (int i = 0; i < 5; i++) if (sel_tbl[i] == b) m_sel = i;
    end
    for (int i = 0; i < 6; i++) begin
      if (ctl_tbl[i] == b && ctl_ext[i] == ext) begin
        if (!brk) begin
          if (!m_held[i] || REP) m_pulse[i] = 1'b1;
          m_held[i] = 1'b1;
        end else begin
          m_held[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit ign = 1'b0;
    for (int i = 0; i < 6; i++) if (ign_tbl[i] == b) ign = 1'b1;
    if (pre.size() > 0 && gap >= T) pre.delete();  // abandoned prefix
    if (pre.size() == 0) begin
      if (b == 8'hE0 || b == 8'hF0) pre.push_back(b);
      else if (!ign) model_event(1'b0, 1'b0, b);
    end else if (pre.size() == 1 && pre[0] == 8'hE0) begin
      if (b == 8'hF0) pre.push_back(b);
      else begin pre.delete(); model_event(1'b0, 1'b1, b); end
    end else if (pre.size() == 1) begin
      pre.delete();
      if (b != 8'hE0) model_event(1'b1, 1'b0, b);
    end else begin
      pre.delete();
      if (b != 8'hE0 && b != 8'hF0) model_event(1'b1, 1'b1, b);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [5:0] dut_pulses();
    return {ADSR_plus_plus, ADSR_minus_minus, amp_plus_plus,
            amp_minus_minus, octave_plus_plus, octave_minus_minus};
  endfunction

  // One clock cycle: optionally strobe a byte, then compare all outputs.
  task automatic step(input bit v, input logic [7:0] b);
    logic [5:0] e;
    logic [5:0] p;
    m_pulse = '0;
    if (v) begin model_byte(b); gap = 0; end
    else gap++;
    exp_q.push_back(m_pulse);
    rx_valid = v;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    p = dut_pulses();
    e = exp_q.pop_front();
    for (int i = 0; i < 6; i++) if (p[i]) pulse_cnt[i]++;
    check("pulses", 32'(p), 32'(e));
    check("note", 32'(note), 32'(m_note));
    check("note_in", 32'(note_in), 32'(m_in));
    check("selector", 32'(ADSR_selector), 32'(m_sel));
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset = 1'b1;
    #2;
    // Asynchronous: outputs must already be cleared before any clock edge
    check("rst_note", 32'(note), 32'd0);
    check("rst_note_in", 32'(note_in), 32'd0);
    check("rst_pulses", 32'(dut_pulses()), 32'd0);
    check("rst_selector", 32'(ADSR_selector), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 6; i++) pulse_cnt[i] = 0;
  endtask

  function automatic logic [7:0] pick_byte();
    int r = $urandom_range(0, 9);
    if (r <= 3) return note_tbl[$urandom_range(0, 12)];
    if (r == 4) return ctl_tbl[$urandom_range(0, 5)];
    if (r == 5) return sel_tbl[$urandom_range(0, 4)];
    if (r == 6) return 8'hE0;
    if (r == 7) return 8'hF0;
    if (r == 8) return ign_tbl[$urandom_range(0, 5)];
    return 8'($urandom_range(0, 255));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    clear_counts();
    #3;
    do_reset();

    // Note make then break
    send(8'h1C);
    check("tp1_note", 32'(note), 32'd0);
    check("tp1_note_in", 32'(note_in), 32'd1);
    send(8'hF0); send(8'h1C);
    check("tp1_brk_in", 32'(note_in), 32'd0);
    check("tp1_brk_note", 32'(note), 32'd0);

    // Last-pressed priority; releasing the older key does nothing
    send(8'h1C); send(8'h24); send(8'hF0); send(8'h1C);
    check("tp2_note", 32'(note), 32'd3);
    check("tp2_note_in", 32'(note_in), 32'd1);
    send(8'hF0); send(8'h24);
    check("tp2_rel_in", 32'(note_in), 32'd0);

    // Typematic repeat of octave+
    clear_counts();
    send(8'h22); send(8'h22); send(8'h22); send(8'hF0); send(8'h22);
    idle(2);
    check("tp3_oct_plus_cnt", 32'(pulse_cnt[1]), REP ? 32'd3 : 32'd1);

    // Selector and extended ADSR+
    clear_counts();
    send(8'h26); send(8'hE0); send(8'h74);
    check("tp4_sel", 32'(ADSR_selector), 32'd2);
    send(8'hE0); send(8'hF0); send(8'h74);
    idle(1);
    check("tp4_adsr_plus_cnt", 32'(pulse_cnt[5]), 32'd1);

    // F0 followed by a short gap still forms a break (no pulse)
    clear_counts();
    send(8'hF0); idle(3); send(8'h1A);
    check("tp5_short_gap", 32'(pulse_cnt[0]), 32'd0);
    // F0 abandoned after the timeout: 1A is a make
    send(8'hF0); idle(T + 4); send(8'h1A);
    check("tp5_timeout_make", 32'(pulse_cnt[0]), 32'd1);
    send(8'hF0); send(8'h1A);

    // Reset in the middle of E0 6B
    clear_counts();
    send(8'hE0);
    do_reset();
    send(8'h6B);
    idle(1);
    check("tp6_adsr_minus_cnt", 32'(pulse_cnt[4]), 32'd0);
    check("tp6_note_in", 32'(note_in), 32'd0);
    check("tp6_selector", 32'(ADSR_selector), 32'd0);

    // Randomized stream
    for (int n = 0; n < 4000; n++) begin
      int g = $urandom_range(0, 39);
      if (g == 39 && $urandom_range(0, 9) == 0) do_reset();
      else if (g == 38) idle(T + $urandom_range(2, 6));
      else if (g >= 32) idle($urandom_range(1, 3));
      send(pick_byte());
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
